// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
//   state_t : post-processing FSM state encoding
//   ACT_W   : activation width (int8)
//   ACT_MAX : largest activation after ReLU + saturation
package cnn_pkg;

   localparam int unsigned ACT_W   = 8;
   localparam int          ACT_MAX = 127;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WAIT  = 3'd2,
      RUN   = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/requant_unit.sv
// Combinational requantiser: bias add, ReLU, right shift, saturation to int8.
// Optional feature macro: POSTPROC_ROUND_EN (round-half-up before the shift).
// Ports:
//   acc  : signed accumulator value (ACC_W)
//   bias : signed int8 bias, aligned internally by BIAS_SHL
//   q_c  : requantised activation, 0..ACT_MAX
module requant_unit
   import cnn_pkg::*;
#(
   parameter int unsigned ACC_W    = 20,
   parameter int unsigned BIAS_SHL = 7,
   parameter int unsigned SHIFT    = 7
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic signed [ACT_W-1:0] bias,
   output logic signed [ACT_W-1:0] q_c
);

   // Two guard bits cover the bias add without overflow.
   localparam int unsigned S_W = ACC_W + 2;

   logic signed [S_W-1:0] acc_x;
   logic signed [S_W-1:0] bias_x;
   logic signed [S_W-1:0] s;
   logic signed [S_W-1:0] r;
   logic signed [S_W-1:0] t;

   always_comb begin
      acc_x  = S_W'(acc);
      bias_x = S_W'(bias) <<< BIAS_SHL;
      s      = acc_x + bias_x;
      r      = s[S_W-1] ? '0 : s;
`ifdef POSTPROC_ROUND_EN
      t      = (r + (S_W'(1) <<< (SHIFT - 1))) >>> SHIFT;
`else
      t      = r >>> SHIFT;
`endif
      q_c    = (t > S_W'(ACT_MAX)) ? ACT_W'(ACT_MAX) : t[ACT_W-1:0];
   end

endmodule

// File: rtl/conv_postproc.sv
// Conv post-processing: per output channel, fetches the bias from the bias ROM,
// then requantises PIX accumulator beats into int8 activations.
// Optional feature macro: POSTPROC_ROUND_EN (passed through to requant_unit).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : 1-cycle pulse, begins an OC+1 channel pass (ignored unless idle)
//   acc_in/valid/ready: accumulator stream from the MAC array
//   out_c, c_load     : bias ROM address and load strobe
//   bias              : bias from ROM, valid 1 cycle after c_load
//   q_out/valid/ready : activation stream to pooling / feature-map buffer
//   busy, done        : pass in progress, 1-cycle completion pulse
module conv_postproc
   import cnn_pkg::*;
#(
   parameter int unsigned OC       = 7,
   parameter int unsigned PIX      = 576,
   parameter int unsigned ACC_W    = 20,
   parameter int unsigned BIAS_SHL = 7,
   parameter int unsigned SHIFT    = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [ACC_W-1:0] acc_in,
   input  logic                    acc_valid,
   output logic                    acc_ready,
   output logic [3:0]              out_c,
   output logic                    c_load,
   input  logic signed [ACT_W-1:0] bias,
   output logic signed [ACT_W-1:0] q_out,
   output logic                    q_valid,
   input  logic                    q_ready,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned CH_W  = 4;
   localparam int unsigned PIX_W = (PIX > 1) ? $clog2(PIX) : 1;

   state_t                  state, state_n;
   logic [CH_W-1:0]         ch, ch_n;
   logic [PIX_W-1:0]        pix, pix_n;
   logic signed [ACT_W-1:0] bias_r;
   logic signed [ACT_W-1:0] q_next_c;
   logic                    beat_c;

   // Upstream may only advance while the output slot is free or retiring.
   assign acc_ready = (state == RUN) && (!q_valid || q_ready);
   assign beat_c    = acc_valid && acc_ready;

   requant_unit #(
      .ACC_W   (ACC_W),
      .BIAS_SHL(BIAS_SHL),
      .SHIFT   (SHIFT)
   ) u_requant (
      .acc (acc_in),
      .bias(bias_r),
      .q_c (q_next_c)
   );

   // Next-state and counter logic.
   always_comb begin
      state_n = state;
      ch_n    = ch;
      pix_n   = pix;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = LOAD;
               ch_n    = '0;
               pix_n   = '0;
            end
         end
         LOAD: state_n = WAIT;
         WAIT: state_n = RUN;
         RUN: begin
            if (beat_c) begin
               if (pix == PIX_W'(PIX - 1)) begin
                  pix_n = '0;
                  if (ch == CH_W'(OC)) begin
                     state_n = DRAIN;
                  end else begin
                     ch_n    = ch + CH_W'(1);
                     state_n = LOAD;
                  end
               end else begin
                  pix_n = pix + PIX_W'(1);
               end
            end
         end
         DRAIN: begin
            if (!q_valid) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State, counters and registered outputs (decoded from the next state).
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ch      <= '0;
         pix     <= '0;
         bias_r  <= '0;
         out_c   <= '0;
         c_load  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         q_out   <= '0;
         q_valid <= 1'b0;
      end else begin
         state  <= state_n;
         ch     <= ch_n;
         pix    <= pix_n;
         out_c  <= ch_n;
         c_load <= (state_n == LOAD);
         busy   <= (state_n != IDLE);
         done   <= (state_n == DONE);
         // ROM output has settled by the WAIT cycle; hold it for the channel.
         if (state == WAIT) bias_r <= bias;
         if (beat_c) begin
            q_out   <= q_next_c;
            q_valid <= 1'b1;
         end else if (q_ready) begin
            q_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv_postproc.sv
// Scoreboard bench for conv_postproc with a small configuration (2 channels x 4 beats).
module tb_conv_postproc;

   localparam int unsigned OC       = 1;
   localparam int unsigned PIX      = 4;
   localparam int unsigned ACC_W    = 20;
   localparam int unsigned BIAS_SHL = 7;
   localparam int unsigned SHIFT    = 7;
   localparam int          NBEAT    = (OC + 1) * PIX;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic signed [ACC_W-1:0] acc_in;
   logic                    acc_valid;
   logic                    acc_ready;
   logic [3:0]              out_c;
   logic                    c_load;
   logic signed [7:0]       bias = '0;
   logic signed [7:0]       q_out;
   logic                    q_valid;
   logic                    q_ready;
   logic                    busy;
   logic                    done;

   logic signed [7:0] rom [0:15];

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int cload_log[$];
   int out_cnt  = 0;
   int done_cnt = 0;

   conv_postproc #(
      .OC(OC), .PIX(PIX), .ACC_W(ACC_W), .BIAS_SHL(BIAS_SHL), .SHIFT(SHIFT)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .acc_in(acc_in), .acc_valid(acc_valid), .acc_ready(acc_ready),
      .out_c(out_c), .c_load(c_load), .bias(bias),
      .q_out(q_out), .q_valid(q_valid), .q_ready(q_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Registered bias ROM: data valid the cycle after c_load.
   always @(posedge clk) if (c_load) bias <= rom[out_c];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: bias scaled to accumulator units, ReLU, divide by 2^SHIFT, clamp.
   function automatic int model(input int acc, input int b);
      int s;
      int r;
      int t;
      s = acc + b * (1 << BIAS_SHL);
      r = (s < 0) ? 0 : s;
`ifdef POSTPROC_ROUND_EN
      t = (r + (1 << (SHIFT - 1))) / (1 << SHIFT);
`else
      t = r / (1 << SHIFT);
`endif
      return (t > 127) ? 127 : t;
   endfunction

   // Monitor: retire outputs against the scoreboard and watch stall behaviour.
   logic prev_hold = 1'b0;
   int   prev_q    = 0;
   always @(negedge clk) begin
      #2;
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", int'(q_valid), 1);
            chk("hold_stable", int'(q_out), prev_q);
         end
         if (q_valid && !q_ready) chk("stall_acc_ready", int'(acc_ready), 0);
         if (c_load) cload_log.push_back(int'(out_c));
         if (done) done_cnt++;
         if (q_valid && q_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL q_unexpected actual=%0d required=none", int'(q_out));
            end else begin
               chk("q_out", int'(q_out), exp_q.pop_front());
            end
         end
         prev_hold = q_valid && !q_ready;
         prev_q    = int'(q_out);
      end
   end

   task automatic rand_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
   endtask

   function automatic int rand_acc();
      if ($urandom_range(0, 1) == 0)
         return int'($urandom_range(0, 40000)) - 20000;
      return int'($urandom_range(0, (1 << ACC_W) - 1)) - (1 << (ACC_W - 1));
   endfunction

   // Modes: 0 zeros, 1 directed values, 2 random, 3 random + 5-cycle stall,
   //        4 reset in ch1, 5 repeated start while busy.
   task automatic run_pass(input int mode);
      int  vals [8] = '{-1000, 200000, 191, 192, 0, 127, 128, 16383};
      int  k = 0;
      int  cyc = 0;
      int  hold = 0;
      bit  hold_done = 1'b0;
      bit  fin = 1'b0;
      int  d0;
      int  o0;
      int  a;
      d0 = done_cnt;
      o0 = out_cnt;
      cload_log.delete();
      while (!fin) begin
         @(negedge clk);
         start = (cyc == 0) || (mode == 5 && cyc == 10);
         case (mode)
            0: a = 0;
            1: a = vals[k % 8];
            default: a = rand_acc();
         endcase
         acc_in    = ACC_W'(a);
         acc_valid = (mode == 2 || mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
         q_ready   = (mode == 2 || mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (mode == 3 && k == PIX + 1 && !hold_done) begin
            hold      = 5;
            hold_done = 1'b1;
         end
         if (hold > 0) begin
            q_ready = 1'b0;
            hold--;
         end
         if (mode == 4 && k == PIX + 2) begin
            rst       = 1'b1;
            acc_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("rst_q_valid", int'(q_valid), 0);
            chk("rst_q_out", int'(q_out), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_c_load", int'(c_load), 0);
            chk("rst_out_c", int'(out_c), 0);
            chk("rst_acc_ready", int'(acc_ready), 0);
            exp_q.delete();
            repeat (10) @(negedge clk);
            #3;
            chk("rst_no_done", done_cnt - d0, 0);
            chk("rst_idle_busy", int'(busy), 0);
            return;
         end
         #1;
         if (acc_valid && acc_ready) begin
            exp_q.push_back(model(a, int'(rom[k / PIX])));
            k++;
         end
         if (done) fin = 1'b1;
         cyc++;
         if (cyc > 2000 && !fin) begin
            checks++;
            errors++;
            $display("FAIL pass_timeout actual=%0d required=%0d beats", k, NBEAT);
            fin = 1'b1;
         end
      end
      @(negedge clk);
      start     = 1'b0;
      acc_valid = 1'b0;
      #3;
      chk("beats_in", k, NBEAT);
      chk("beats_out", out_cnt - o0, NBEAT);
      chk("done_pulses", done_cnt - d0, 1);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("busy_after_done", int'(busy), 0);
      chk("c_load_count", cload_log.size(), OC + 1);
      for (int i = 0; i < cload_log.size(); i++) chk("c_load_out_c", cload_log[i], i);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      acc_valid = 1'b0;
      acc_in    = '0;
      q_ready   = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_q_valid", int'(q_valid), 0);
      chk("reset_q_out", int'(q_out), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_c_load", int'(c_load), 0);
      chk("reset_out_c", int'(out_c), 0);
      chk("reset_acc_ready", int'(acc_ready), 0);
      rst = 1'b0;

      rom[0] = 8'sd3;
      rom[1] = -8'sd2;
      run_pass(0);

      rom[0] = '0;
      rom[1] = '0;
      run_pass(1);

      for (int i = 0; i < 6; i++) begin
         rand_rom();
         run_pass(2);
      end
      for (int i = 0; i < 2; i++) begin
         rand_rom();
         run_pass(3);
      end

      rand_rom();
      run_pass(4);
      rom[0] = 8'sd3;
      rom[1] = -8'sd2;
      run_pass(0);
      rand_rom();
      run_pass(5);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
